rom_burst_reader: RTL
=====================

# rom_burst_reader

Bus-master read engine sitting directly upstream of the ROM slave wrapper on the system bus. It accepts a block-read command (base address, word count) from the core, issues one single-beat read transaction per word over the valid/ready/last bus handshake, and streams the returned 16-bit words to the consumer through a 4-entry output FIFO with valid/ready flow control. Bus requests are throttled so a returning word always has a FIFO slot.

## Interface
- ADDR_W, 12, bus address width (matches `BUS_ADDR_BITS`)
- DATA_W, 16, bus data width (matches `BUS_DATA_BITS`)
- LEN_W, 10, command word-count width
- BLEN_W, 10, bus burst-length field width (matches `BUS_LEN_BITS`)
- FIFO_DEPTH, 4, output FIFO entries (power of two)

- bus_clk  in  1  system bus clock; all state on rising edge
- bus_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; accepted only when busy=0
- start_addr  in  ADDR_W  first word address
- start_len  in  LEN_W  number of words (0 allowed)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse: final word written into FIFO (or zero-length command retired)
- dout_valid  out  1  FIFO not empty
- dout_data  out  DATA_W  FIFO head word
- dout_ready  in  1  consumer pops head when dout_valid & dout_ready
- ADDR_M  out  ADDR_W  bus read address, stable while RVALID_M=1
- BLEN_M  out  BLEN_W  bus burst length; constant 1
- RVALID_M  out  1  bus read request
- RREADY_M  in  1  slave accepted request
- RDATA_M  in  DATA_W  slave read data, valid when RLAST_M=1
- RLAST_M  in  1  final (only) data beat

## Operation
- States: IDLE, REQ, WAIT_LAST, HOLD, FIN.
- IDLE: start=1 latches addr←start_addr, remaining←start_len, busy←1. Next: FIN if start_len=0; else REQ if FIFO count<FIFO_DEPTH, else HOLD.
- HOLD: RVALID_M=0; leave to REQ on first cycle count<FIFO_DEPTH.
- REQ: RVALID_M=1 (decoded from state), ADDR_M=addr. On RREADY_M=1 → WAIT_LAST (RVALID_M drops next cycle so slave does not re-trigger).
- WAIT_LAST: RVALID_M=0. On RLAST_M=1: push RDATA_M to FIFO, addr←addr+1 (wraps mod 2^ADDR_W, 0xFFF→0x000), remaining←remaining−1. If remaining was 1 → FIN; else REQ if slot free after this push/pop, else HOLD.
- FIN: done=1 for one cycle, busy←0, → IDLE.
- At most one outstanding bus transaction; REQ entered only when FIFO has a free slot, so RLAST data is never dropped.
- start while busy=1: ignored, no state change.
- FIFO: simultaneous push and pop keeps count; pop when empty impossible (dout_valid=0). FIFO contents persist after done; new command may start with data still queued.
- RDATA_M/RLAST_M outside WAIT_LAST ignored.

## Timing
- Reset values: busy=0, done=0, dout_valid=0, dout_data=0, RVALID_M=0, ADDR_M=0, BLEN_M=1, state IDLE, FIFO empty, pointers/count 0.
- Reset asserted mid-command aborts immediately; queued FIFO data discarded; no done pulse.
- With slave timing (RREADY one cycle after RVALID seen, RLAST the cycle after RREADY): start in cycle 0 → RVALID_M cycles 1–2 → RLAST_M cycle 3 → dout_valid cycle 4.
- Steady state with consumer always ready: one word per 3 cycles.
- done asserted in the cycle after the final RLAST_M; busy falls together with done's trailing edge (busy=0 in cycle after done).
- Zero-length command: done in cycle 2 after start, no bus activity.
- dout_data registered from FIFO storage; no combinational path from RDATA_M to dout_data.

## Test plan
- Single word: start_addr=0x010, len=1, ROM[0x010]=0xABCD, dout_ready=1 → one RVALID_M pulse with ADDR_M=0x010, dout_data=0xABCD at cycle 4, done once, busy low after.
- Burst of 8 from 0x100, dout_ready=1 → ADDR_M 0x100..0x107 in order, 8 words in order, 3-cycle spacing, exactly one done.
- Backpressure: len=6, dout_ready=0 → exactly 4 bus transactions then HOLD, dout_valid stays 1; release dout_ready → remaining 2 fetched, all 6 words correct, no loss/duplication.
- Wrap: start_addr=0xFFE, len=4 → ADDR_M 0xFFE,0xFFF,0x000,0x001.
- Zero length and start-while-busy: len=0 → done at cycle 2, RVALID_M never high; start pulsed during an active len=5 command → ignored, original 5 words only.
- Reset mid-burst: assert bus_rst during WAIT_LAST of word 3 of 8 → all outputs at reset values next cycle, FIFO empty; fresh command afterwards completes correctly.

Source files
------------

// File: rtl/rom_burst_reader.sv
// Purpose: block-read bus master; fetches start_len words from start_addr, one single-beat read each, into a 4-entry output FIFO.
// Latency: start -> RVALID_M next cycle; RLAST_M -> dout_valid next cycle; steady state one word per 3 cycles.
// Backpressure: a new bus request is issued only while the FIFO has a free slot, so returned data never overflows.
//
// Ports:
//   bus_clk, bus_rst                : clock, asynchronous active-high reset
//   start, start_addr, start_len    : command strobe (ignored while busy), first address, word count (0 allowed)
//   busy, done                      : command in progress, one-cycle completion pulse
//   dout_valid, dout_data, dout_ready : output stream (FIFO head), popped on valid & ready
//   ADDR_M, BLEN_M, RVALID_M, RREADY_M, RDATA_M, RLAST_M : bus read master side
module rom_burst_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 10,
    parameter int BLEN_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    output logic              busy,
    output logic              done,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout_data,
    input  logic              dout_ready,
    output logic [ADDR_W-1:0] ADDR_M,
    output logic [BLEN_W-1:0] BLEN_M,
    output logic              RVALID_M,
    input  logic              RREADY_M,
    input  logic [DATA_W-1:0] RDATA_M,
    input  logic              RLAST_M
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LAST,
        S_HOLD,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_slot_now;
    logic              w_slot_after;

    // Response data is only meaningful while waiting for our one outstanding beat.
    assign w_push       = (r_state == S_WAIT_LAST) && RLAST_M;
    assign w_pop        = dout_valid && dout_ready;
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_slot_now   = (r_count < DEPTH_C);
    assign w_slot_after = (w_count_nxt < DEPTH_C);

    assign busy       = r_busy;
    assign done       = r_done;
    assign dout_valid = (r_count != '0);
    assign dout_data  = r_mem[r_rd_ptr];
    assign ADDR_M     = r_addr;
    assign BLEN_M     = BLEN_W'(1);
    assign RVALID_M   = (r_state == S_REQ);

    // Output FIFO; storage is cleared on reset so the head reads zero when empty after reset.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= RDATA_M;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= start_addr;
                        r_remaining <= start_len;
                        r_busy      <= 1'b1;
                        if (start_len == '0) begin
                            r_state <= S_FIN;
                        end else if (w_slot_now) begin
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_slot_now) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (RREADY_M) begin
                        r_state <= S_WAIT_LAST;
                    end
                end
                S_WAIT_LAST: begin
                    if (RLAST_M) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            // Raise done together with the final push so it appears the cycle after RLAST_M.
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else if (w_slot_after) begin
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_FIN: begin
                    // A zero-length command arrives here with done still low and spends
                    // one extra cycle raising it; otherwise done is already high.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
